tone_sequence_detector: RTL and testbench
=========================================

// Module: tone_sequence_detector
// PURPOSE
// - Parametrised successor to the single-frame tone FSM; consumes the FFT magnitude stream, finds the peak bin per frame.
// - Classifies each peak into one of NUM_TONES bands.
// - Collects NUM_FRAMES classifications and reports them as one packed sequence over a valid/ready handshake.
// - Sits between the FFT magnitude stage and the tone-decode/control logic.
// PARAMETERS
// - DATA_W        32  unsigned magnitude width per bin
// - NFFT          64  FFT length; bins per frame (power of 2, >=8)
// - NUM_FRAMES    3   frames collected per report
// - NUM_TONES     4   tone bands; codes 1..NUM_TONES, 0 = none
// - TONE_BASE     8   first bin of band 1
// - TONE_STEP_LOG2 2  band width = 2**TONE_STEP_LOG2 bins
// - SNR_SHIFT     3   peak<<SNR_SHIFT must be >= frame sum (TONE_SNR_EN only)
// - derived: BIN_W=$clog2(NFFT), TONE_W=$clog2(NUM_TONES+1)
// PORTS
// - clk_in     in   1                      single clock
// - rst_in_n   in   1                      asynchronous active-low reset
// - s_valid    in   1                      magnitude beat valid
// - s_last     in   1                      last beat of frame
// - s_data     in   DATA_W                 bin magnitude, bins in order 0..NFFT-1
// - s_ready    out  1                      beat accepted when s_valid&&s_ready
// - min_mag    in   DATA_W                 peak below this -> code 0; sampled in CLASSIFY
// - out_seq    out  NUM_FRAMES*TONE_W      frame k code at [k*TONE_W +: TONE_W], frame 0 LSB
// - out_valid  out  1                      sequence valid; held until out_ready
// - out_ready  in   1                      downstream accept
// - frame_err  out  1                      1-cycle pulse: malformed frame discarded
// BEHAVIOUR
// - Reset (async assert, sync release): state=SCAN, s_ready=1, out_valid=0, out_seq=0, frame_err=0, counters/history/peak=0.
// - States: SCAN, DROP, CLASSIFY, REPORT.
// - SCAN: s_ready=1; per accepted beat bin_cnt++.
//   - Peak search covers bins 1..NFFT/2-1 only (DC, negative half counted but ignored).
//   - Update peak only on strictly greater: ties keep the lowest bin.
// - Last beat (s_last at bin_cnt==NFFT-1) -> CLASSIFY.
// - s_last with bin_cnt!=NFFT-1: frame_err pulse next cycle, frame discarded, bin_cnt=0, stay SCAN.
// - bin_cnt==NFFT-1 without s_last: frame_err pulse, -> DROP.
// - DROP: s_ready=1, discard beats until one with s_last, then -> SCAN with bin_cnt=0.
// - CLASSIFY (1 cycle, s_ready=0):
//   - code = ((peak_bin-TONE_BASE)>>TONE_STEP_LOG2)+1 if TONE_BASE <= peak_bin < TONE_BASE+(NUM_TONES<<TONE_STEP_LOG2) and peak_mag>=min_mag;
//   - otherwise code = 0.
//   - Store code in history[frame_cnt]; clear peak.
//   - If frame_cnt==NUM_FRAMES-1 -> REPORT, else frame_cnt++ and -> SCAN.
// - REPORT: s_ready=0; out_seq=history, out_valid=1.
//   - out_valid rises 2 cycles after the final last beat is accepted.
//   - out_seq stable while out_valid && !out_ready.
//   - On out_ready: out_valid=0, frame_cnt=0, history=0, -> SCAN next cycle.
// - Magnitude compare unsigned DATA_W; no arithmetic overflow possible except SNR sum, sized DATA_W+BIN_W.
// - Reset mid-frame or mid-report: everything returns to reset values immediately; partial frame lost.
// CONFIGURATION
// - `define TONE_SNR_EN:
//   - Accumulate the sum of scanned-bin magnitudes per frame (width DATA_W+BIN_W).
//   - In CLASSIFY, force code 0 unless (peak_mag<<SNR_SHIFT) >= sum.
// - Without the macro: no accumulator; classification uses min_mag and band range only.
// STRUCTURE
// - Package tone_det_pkg:
//   - state enum {SCAN,DROP,CLASSIFY,REPORT};
//   - TONE_NONE=0 constant;
//   - function classify_bin(bin, base, step_log2, num_tones) returning tone code.
// - Sub-module tone_peak_tracker: running max/argmax with clear, bin-window enable and optional SNR accumulator.
// - FSM, counters and history live in the top.
// TESTING (NFFT=64, TONE_BASE=8, TONE_STEP_LOG2=2, NUM_TONES=4, NUM_FRAMES=3, TONE_W=3, min_mag=100, other bins=10)
// - Peaks 1000 at bins 9,13,21 in frames 0..2 -> out_seq=0x111 (codes 1,2,4); out_valid 2 cycles after third last.
// - Peak at bin 30; peak 50 at bin 9; peak at bin 40 (negative half) -> codes 0 in the respective slots.
// - Bins 9 and 14 both 500 -> code 1 (lowest bin wins tie).
// - s_last on beat 40 -> one frame_err pulse, frame not counted; next 3 good frames report normally.
// - 70 beats without s_last then a last -> frame_err pulse, DROP resyncs; next frames report.
// - out_ready low 10 cycles -> out_seq/out_valid stable, s_ready=0; one-cycle out_ready -> back to SCAN.
// - rst_in_n low mid-frame -> outputs at reset values same cycle; clean frames after release report correctly.
// - TONE_SNR_EN, SNR_SHIFT=3: peak 1000 at bin 9 with all other bins 200 -> code 0; other bins 10 -> code 1.

Source files
------------

// File: rtl/tone_sequence_detector_pkg.sv
// Shared types and helpers for the tone sequence detector.
// Build option: TONE_SNR_EN enables the per-frame SNR gate.
package tone_det_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DROP,
    CLASSIFY,
    REPORT
  } state_t;

  localparam int unsigned TONE_NONE = 0;

  function automatic int unsigned classify_bin(
    input int unsigned bin,
    input int unsigned base,
    input int unsigned step_log2,
    input int unsigned num_tones
  );
    int unsigned hi;
    hi = base + (num_tones << step_log2);
    if (bin >= base && bin < hi)
      return ((bin - base) >> step_log2) + 1;
    return TONE_NONE;
  endfunction

endpackage

// File: rtl/tone_sequence_detector_if.sv
// Magnitude stream in, packed tone sequence out.
// Build option: TONE_SNR_EN (no effect on this interface).
interface tone_seq_if #(
  parameter int DATA_W = 32,
  parameter int SEQ_W  = 9
) ();
  logic              s_valid;
  logic              s_last;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic [DATA_W-1:0] min_mag;
  logic [SEQ_W-1:0]  out_seq;
  logic              out_valid;
  logic              out_ready;
  logic              frame_err;

  modport master (
    output s_valid, s_last, s_data, min_mag, out_ready,
    input  s_ready, out_seq, out_valid, frame_err
  );

  modport slave (
    input  s_valid, s_last, s_data, min_mag, out_ready,
    output s_ready, out_seq, out_valid, frame_err
  );
endinterface

// File: rtl/tone_sequence_detector_peak.sv
// Running max/argmax over a bin window, optional magnitude sum.
// Build option: TONE_SNR_EN adds the frame sum accumulator.
module tone_peak_tracker #(
  parameter int DATA_W = 32,
  parameter int BIN_W  = 6
) (
  input  logic                    clk_in,
  input  logic                    rst_in_n,
  input  logic                    clear,
  input  logic                    win_en,
`ifdef TONE_SNR_EN
  input  logic                    acc_en,
  output logic [DATA_W+BIN_W-1:0] sum,
`endif
  input  logic [DATA_W-1:0]       data,
  input  logic [BIN_W-1:0]        bin,
  output logic [DATA_W-1:0]       peak_mag,
  output logic [BIN_W-1:0]        peak_bin
);

  // Strictly-greater update keeps the lowest bin on ties.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      peak_mag <= '0;
      peak_bin <= '0;
    end else if (clear) begin
      peak_mag <= '0;
      peak_bin <= '0;
    end else if (win_en && data > peak_mag) begin
      peak_mag <= data;
      peak_bin <= bin;
    end
  end

`ifdef TONE_SNR_EN
  // Sum of every scanned beat of the frame.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n)
      sum <= '0;
    else if (clear)
      sum <= '0;
    else if (acc_en)
      sum <= sum + (DATA_W+BIN_W)'(data);
  end
`endif

endmodule

// File: rtl/tone_sequence_detector.sv
// Per-frame peak classification, packed over NUM_FRAMES frames.
// Build option: TONE_SNR_EN gates codes on peak vs frame energy.
module tone_sequence_detector
  import tone_det_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int NFFT           = 64,
  parameter int NUM_FRAMES     = 3,
  parameter int NUM_TONES      = 4,
  parameter int TONE_BASE      = 8,
  parameter int TONE_STEP_LOG2 = 2
`ifdef TONE_SNR_EN
  ,
  parameter int SNR_SHIFT      = 3
`endif
) (
  input logic      clk_in,
  input logic      rst_in_n,
  tone_seq_if.slave bus
);

  localparam int BIN_W  = $clog2(NFFT);
  localparam int TONE_W = $clog2(NUM_TONES + 1);
  localparam int SEQ_W  = NUM_FRAMES * TONE_W;
  localparam int FC_W   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NFFT - 1);
  localparam logic [BIN_W-1:0] HALF_BIN = BIN_W'(NFFT / 2);
  localparam logic [FC_W-1:0]  LAST_FC  = FC_W'(NUM_FRAMES - 1);

  state_t            state_q, state_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [FC_W-1:0]   fc_q, fc_d;
  logic [SEQ_W-1:0]  hist_q, hist_d;
  logic              err_q, err_d;
  logic              clear;
  logic              beat;
  logic              win_en;
  logic              snr_ok;
  logic [DATA_W-1:0] peak_mag;
  logic [BIN_W-1:0]  peak_bin;
  logic [TONE_W-1:0] code;

  assign bus.s_ready   = (state_q == SCAN) || (state_q == DROP);
  assign bus.out_valid = (state_q == REPORT);
  assign bus.out_seq   = bus.out_valid ? hist_q : '0;
  assign bus.frame_err = err_q;

  assign beat   = bus.s_valid && bus.s_ready;
  assign win_en = beat && (state_q == SCAN) &&
                  (bin_q != '0) && (bin_q < HALF_BIN);

`ifdef TONE_SNR_EN
  localparam int SUM_W = DATA_W + BIN_W;
  localparam int SH_W  = SUM_W + SNR_SHIFT;
  logic [SUM_W-1:0] sum;

  tone_peak_tracker #(
    .DATA_W (DATA_W),
    .BIN_W  (BIN_W)
  ) u_peak (
    .clk_in   (clk_in),
    .rst_in_n (rst_in_n),
    .clear    (clear),
    .win_en   (win_en),
    .acc_en   (beat && (state_q == SCAN)),
    .sum      (sum),
    .data     (bus.s_data),
    .bin      (bin_q),
    .peak_mag (peak_mag),
    .peak_bin (peak_bin)
  );

  assign snr_ok = (SH_W'(peak_mag) << SNR_SHIFT) >= SH_W'(sum);
`else
  tone_peak_tracker #(
    .DATA_W (DATA_W),
    .BIN_W  (BIN_W)
  ) u_peak (
    .clk_in   (clk_in),
    .rst_in_n (rst_in_n),
    .clear    (clear),
    .win_en   (win_en),
    .data     (bus.s_data),
    .bin      (bin_q),
    .peak_mag (peak_mag),
    .peak_bin (peak_bin)
  );

  assign snr_ok = 1'b1;
`endif

  // Band code for the current peak, squelched when too weak.
  always_comb begin
    code = TONE_W'(classify_bin(32'(peak_bin), TONE_BASE,
                                TONE_STEP_LOG2, NUM_TONES));
    if (peak_mag < bus.min_mag || !snr_ok)
      code = TONE_W'(TONE_NONE);
  end

  // Frame framing, classification and report sequencing.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    fc_d    = fc_q;
    hist_d  = hist_q;
    err_d   = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      SCAN: begin
        if (beat) begin
          if (bin_q == LAST_BIN) begin
            bin_d = '0;
            if (bus.s_last) begin
              state_d = CLASSIFY;
            end else begin
              err_d   = 1'b1;
              clear   = 1'b1;
              state_d = DROP;
            end
          end else if (bus.s_last) begin
            bin_d = '0;
            err_d = 1'b1;
            clear = 1'b1;
          end else begin
            bin_d = bin_q + 1'b1;
          end
        end
      end
      DROP: begin
        if (beat && bus.s_last)
          state_d = SCAN;
      end
      CLASSIFY: begin
        for (int k = 0; k < NUM_FRAMES; k++)
          if (fc_q == FC_W'(k))
            hist_d[k*TONE_W +: TONE_W] = code;
        clear = 1'b1;
        if (fc_q == LAST_FC) begin
          state_d = REPORT;
        end else begin
          fc_d    = fc_q + 1'b1;
          state_d = SCAN;
        end
      end
      REPORT: begin
        if (bus.out_ready) begin
          state_d = SCAN;
          fc_d    = '0;
          hist_d  = '0;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // State, counters, history and error pulse registers.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q <= SCAN;
      bin_q   <= '0;
      fc_q    <= '0;
      hist_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      fc_q    <= fc_d;
      hist_q  <= hist_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_tone_sequence_detector.sv
// Directed bench for tone_sequence_detector.
// Build option: TONE_SNR_EN adds the SNR-gate vectors.
module tb_tone_sequence_detector;

  localparam int DW = 32;
  localparam int SW = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  logic [DW-1:0] mags [128];

  tone_seq_if #(.DATA_W(DW), .SEQ_W(SW)) bus ();

  tone_sequence_detector #(
    .DATA_W         (DW),
    .NFFT           (64),
    .NUM_FRAMES     (3),
    .NUM_TONES      (4),
    .TONE_BASE      (8),
    .TONE_STEP_LOG2 (2)
  ) dut (
    .clk_in   (clk),
    .rst_in_n (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (bus.frame_err === 1'b1) err_cnt++;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build(input logic [DW-1:0] bg,
                       input int bin,
                       input logic [DW-1:0] val);
    for (int i = 0; i < 128; i++) mags[i] = bg;
    mags[bin] = val;
  endtask

  task automatic send(input int nbeats, input int last_at);
    for (int i = 0; i < nbeats; i++) begin
      int n;
      bus.s_valid = 1'b1;
      bus.s_data  = mags[i];
      bus.s_last  = (i == last_at);
      n = 0;
      while (!bus.s_ready && n < 100) begin
        tick();
        n++;
      end
      if (!bus.s_ready) check("ready_tmo", 64'(bus.s_ready), 1);
      tick();
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic frame(input int bin, input logic [DW-1:0] val,
                       input logic [DW-1:0] bg);
    build(bg, bin, val);
    send(64, 63);
  endtask

  task automatic expect_report(input string tag,
                               input logic [SW-1:0] exp,
                               input int stall);
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 64'(bus.out_valid), 1);
    check({tag, "_seq"}, 64'(bus.out_seq), 64'(exp));
    check({tag, "_srdy"}, 64'(bus.s_ready), 0);
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_hold_seq"}, 64'(bus.out_seq), 64'(exp));
      check({tag, "_hold_v"}, 64'(bus.out_valid), 1);
      check({tag, "_hold_rdy"}, 64'(bus.s_ready), 0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_done_v"}, 64'(bus.out_valid), 0);
    check({tag, "_done_rdy"}, 64'(bus.s_ready), 1);
  endtask

  initial begin
    int e0;
    bus.s_valid   = 1'b0;
    bus.s_last    = 1'b0;
    bus.s_data    = '0;
    bus.min_mag   = 32'd100;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_srdy", 64'(bus.s_ready), 1);
    check("rst_oval", 64'(bus.out_valid), 0);
    check("rst_oseq", 64'(bus.out_seq), 0);
    check("rst_ferr", 64'(bus.frame_err), 0);
    rst_n = 1'b1;
    tick();

    // codes 1,2,4 and report latency
    frame(9, 1000, 10);
    frame(13, 1000, 10);
    frame(21, 1000, 10);
    check("lat_cls", 64'(bus.out_valid), 0);
    check("lat_cls_rdy", 64'(bus.s_ready), 0);
    tick();
    check("lat_rep", 64'(bus.out_valid), 1);
    expect_report("basic", 9'h111, 0);
    check("err_none", 64'(err_cnt), 0);

    // out of band, weak peak, negative half
    frame(30, 1000, 10);
    frame(9, 50, 10);
    frame(40, 1000, 10);
    expect_report("zeros", 9'h000, 0);

    // tie between bins 9 and 14 in slot 1
    frame(21, 1000, 10);
    build(10, 9, 500);
    mags[14] = 500;
    send(64, 63);
    frame(13, 1000, 10);
    expect_report("tie", 9'h08C, 0);

    // short frame
    e0 = err_cnt;
    build(10, 13, 1000);
    send(41, 40);
    tick();
    check("short_err", 64'(err_cnt - e0), 1);
    frame(9, 1000, 10);
    frame(9, 1000, 10);
    frame(13, 1000, 10);
    expect_report("short", 9'h089, 0);

    // long frame, drop until last
    e0 = err_cnt;
    build(10, 21, 1000);
    send(71, 70);
    tick();
    check("long_err", 64'(err_cnt - e0), 1);
    frame(13, 1000, 10);
    frame(21, 1000, 10);
    frame(9, 1000, 10);
    expect_report("long", 9'h062, 0);

    // backpressure
    e0 = err_cnt;
    frame(9, 1000, 10);
    frame(13, 1000, 10);
    frame(21, 1000, 10);
    expect_report("stall", 9'h111, 10);
    check("stall_err", 64'(err_cnt - e0), 0);

    // reset mid-frame
    frame(13, 1000, 10);
    build(10, 21, 1000);
    send(20, 99);
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_srdy", 64'(bus.s_ready), 1);
    check("mrst_oval", 64'(bus.out_valid), 0);
    check("mrst_oseq", 64'(bus.out_seq), 0);
    check("mrst_ferr", 64'(bus.frame_err), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    frame(21, 1000, 10);
    frame(21, 1000, 10);
    frame(9, 1000, 10);
    expect_report("mrst", 9'h064, 0);

`ifdef TONE_SNR_EN
    // energy gate
    frame(9, 1000, 200);
    frame(9, 1000, 10);
    frame(13, 1000, 10);
    expect_report("snr", 9'h088, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
